// File: rtl/gshare_branch_predictor_if.sv
// Fetch/update bundle between the IF/EX stages and the gshare branch predictor.
// master = pipeline side, slave = predictor side.
interface gshare_branch_predictor_if #(
  parameter int GHR_WIDTH = 5
);
  logic [31:0]          fetch_pc;
  logic                 fetch_valid;
  logic [31:0]          predicted_pc;
  logic                 predicted_taken;
  logic [GHR_WIDTH-1:0] fetch_ghr;

  logic                 update_valid;
  logic [31:0]          update_pc;
  logic                 update_is_cond;
  logic                 update_taken;
  logic [31:0]          update_target;
  logic [GHR_WIDTH-1:0] update_ghr;
  logic                 update_mispredict;

  modport master (
    output fetch_pc, fetch_valid,
    output update_valid, update_pc, update_is_cond, update_taken,
    output update_target, update_ghr, update_mispredict,
    input  predicted_pc, predicted_taken, fetch_ghr
  );

  modport slave (
    input  fetch_pc, fetch_valid,
    input  update_valid, update_pc, update_is_cond, update_taken,
    input  update_target, update_ghr, update_mispredict,
    output predicted_pc, predicted_taken, fetch_ghr
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter PHT. GSHARE_HISTORY_EN selects gshare
// indexing with speculative global history; otherwise plain bimodal indexing.
module gshare_branch_predictor #(
  parameter int INDEX_WIDTH = 5,
  parameter int GHR_WIDTH   = 5
) (
  input logic                     clk,
  input logic                     reset,
  gshare_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = 30 - INDEX_WIDTH;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [ENTRIES-1:0] cond_q;

  logic [INDEX_WIDTH-1:0] fetch_idx;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [INDEX_WIDTH-1:0] fetch_pht_idx;
  logic [INDEX_WIDTH-1:0] upd_pht_idx;
  logic [TAG_W-1:0]       fetch_tag;
  logic [TAG_W-1:0]       upd_tag;

  logic       hit;
  logic       pred_taken;
  logic       btb_we;
  logic       pht_we;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_upd;
  logic       unused_pc_lsb;

  assign fetch_idx = bp.fetch_pc[INDEX_WIDTH+1:2];
  assign fetch_tag = bp.fetch_pc[31:INDEX_WIDTH+2];
  assign upd_idx   = bp.update_pc[INDEX_WIDTH+1:2];
  assign upd_tag   = bp.update_pc[31:INDEX_WIDTH+2];
  assign unused_pc_lsb = ^{bp.fetch_pc[1:0], bp.update_pc[1:0]};

`ifdef GSHARE_HISTORY_EN
  logic [GHR_WIDTH-1:0]   ghr_q;
  logic [GHR_WIDTH-1:0]   ghr_d;
  logic [INDEX_WIDTH-1:0] ghr_ext;
  logic [INDEX_WIDTH-1:0] upd_ghr_ext;

  generate
    if (INDEX_WIDTH > GHR_WIDTH) begin : g_ghr_zext
      assign ghr_ext     = {{(INDEX_WIDTH-GHR_WIDTH){1'b0}}, ghr_q};
      assign upd_ghr_ext = {{(INDEX_WIDTH-GHR_WIDTH){1'b0}}, bp.update_ghr};
    end else begin : g_ghr_same
      assign ghr_ext     = ghr_q;
      assign upd_ghr_ext = bp.update_ghr;
    end
  endgenerate

  assign fetch_pht_idx = fetch_idx ^ ghr_ext;
  assign upd_pht_idx   = upd_idx ^ upd_ghr_ext;
  assign bp.fetch_ghr  = ghr_q;

  // A resolved mispredict rebuilds history from the snapshot it carried, which
  // supersedes any speculative shift from the wrong-path fetch this cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.update_valid && bp.update_mispredict) begin
      if (bp.update_is_cond)
        ghr_d = {bp.update_ghr[GHR_WIDTH-2:0], bp.update_taken};
      else
        ghr_d = bp.update_ghr;
    end else if (bp.fetch_valid && hit && cond_q[fetch_idx]) begin
      ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  logic unused_bimodal;

  assign fetch_pht_idx  = fetch_idx;
  assign upd_pht_idx    = upd_idx;
  assign bp.fetch_ghr   = '0;
  assign unused_bimodal = ^{bp.update_ghr, bp.update_mispredict, bp.fetch_valid};
`endif

  assign hit        = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken = hit && (!cond_q[fetch_idx] || ctr_q[fetch_pht_idx][1]);

  assign bp.predicted_taken = pred_taken;
  assign bp.predicted_pc    = pred_taken ? target_q[fetch_idx] : bp.fetch_pc + 32'd4;

  assign btb_we  = bp.update_valid && bp.update_taken;
  assign pht_we  = bp.update_valid && bp.update_is_cond;
  assign ctr_cur = ctr_q[upd_pht_idx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (bp.update_taken) begin
      if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign valid_d[gi] = valid_q[gi] | (btb_we && (upd_idx == INDEX_WIDTH'(gi)));
      assign ctr_d[gi]   = (pht_we && (upd_pht_idx == INDEX_WIDTH'(gi))) ? ctr_upd : ctr_q[gi];
    end
  endgenerate

  // Only valid bits and counters need clearing; tag/target/cond are qualified by valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.update_target;
      cond_q[upd_idx]   <= bp.update_is_cond;
    end
  end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench: stimulus queues expected predictions, a negedge
// monitor pops and compares them against the live predictor outputs.
module tb_gshare_branch_predictor;
  logic clk = 1'b0;
  logic reset;

  gshare_branch_predictor_if #(.GHR_WIDTH(5)) bp_if ();

  gshare_branch_predictor #(.INDEX_WIDTH(5), .GHR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  always #5 clk = ~clk;

`ifdef GSHARE_HISTORY_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        taken;
    logic [4:0]  ghr;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_pred(input string name, input logic [31:0] pc,
                             input logic taken, input logic [4:0] ghr);
    exp_t e;
    e.name = name; e.pc = pc; e.taken = taken; e.ghr = ghr;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bp_if.predicted_pc !== e.pc || bp_if.predicted_taken !== e.taken ||
          bp_if.fetch_ghr !== e.ghr) begin
        failures++;
        $display("FAIL %s: got pc=%h taken=%b ghr=%b, want pc=%h taken=%b ghr=%b",
                 e.name, bp_if.predicted_pc, bp_if.predicted_taken, bp_if.fetch_ghr,
                 e.pc, e.taken, e.ghr);
      end else begin
        $display("ok   %s: pc=%h taken=%b ghr=%b", e.name, e.pc, e.taken, e.ghr);
      end
    end
  end

  task automatic cycle(input logic [31:0] fpc, input logic fvalid, input logic uvalid,
                       input logic [31:0] upc, input logic ucond, input logic utaken,
                       input logic [31:0] utarget, input logic [4:0] ughr,
                       input logic umisp);
    @(posedge clk);
    #1;
    bp_if.fetch_pc          = fpc;
    bp_if.fetch_valid       = fvalid;
    bp_if.update_valid      = uvalid;
    bp_if.update_pc         = upc;
    bp_if.update_is_cond    = ucond;
    bp_if.update_taken      = utaken;
    bp_if.update_target     = utarget;
    bp_if.update_ghr        = ughr;
    bp_if.update_mispredict = umisp;
  endtask

  task automatic fetch_only(input logic [31:0] fpc);
    cycle(fpc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'b0, 1'b0);
  endtask

  task automatic train_br40(input logic taken);
    cycle(32'h40, 1'b0, 1'b1, 32'h40, 1'b1, taken, 32'h20, 5'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bp_if.fetch_pc = 32'h100; bp_if.fetch_valid = 1'b0;
    bp_if.update_valid = 1'b0; bp_if.update_pc = '0; bp_if.update_is_cond = 1'b0;
    bp_if.update_taken = 1'b0; bp_if.update_target = '0; bp_if.update_ghr = '0;
    bp_if.update_mispredict = 1'b0;

    repeat (2) @(posedge clk);
    #1 expect_pred("reset_hold", 32'h104, 1'b0, 5'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_pred("cold_start", 32'h104, 1'b0, 5'b0);

    // jal at 0x100 -> 0x200; same-cycle fetch still sees the empty entry
    cycle(32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 5'b0, 1'b1);
    expect_pred("jal_train_cycle", 32'h104, 1'b0, 5'b0);
    fetch_only(32'h100);    expect_pred("jal_hit", 32'h200, 1'b1, 5'b0);
    fetch_only(32'h180);    expect_pred("jal_alias_miss", 32'h184, 1'b0, 5'b0);
    fetch_only(32'hFFFF_FFFC); expect_pred("pc_wrap", 32'h0, 1'b0, 5'b0);

    // counter walk for branch 0x40 -> 0x20, history held at 0
    train_br40(1'b1); expect_pred("br_untrained", 32'h44, 1'b0, 5'b0);
    train_br40(1'b1); expect_pred("ctr_10", 32'h20, 1'b1, 5'b0);
    train_br40(1'b0); expect_pred("ctr_11", 32'h20, 1'b1, 5'b0);
    train_br40(1'b0); expect_pred("ctr_10_down", 32'h20, 1'b1, 5'b0);
    train_br40(1'b0); expect_pred("ctr_01_down", 32'h44, 1'b0, 5'b0);
    train_br40(1'b0); expect_pred("ctr_00", 32'h44, 1'b0, 5'b0);
    train_br40(1'b1); expect_pred("ctr_00_sat", 32'h44, 1'b0, 5'b0);
    train_br40(1'b1); expect_pred("ctr_01_up", 32'h44, 1'b0, 5'b0);
    fetch_only(32'h40); expect_pred("ctr_10_up", 32'h20, 1'b1, 5'b0);

    // same-cycle fetch/update conflict: no bypass
    cycle(32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'b0, 1'b0);
    expect_pred("conflict_old", 32'h20, 1'b1, 5'b0);
    fetch_only(32'h40); expect_pred("conflict_new", 32'h80, 1'b1, 5'b0);

    // repair beats speculative shift from a predicted-taken cond fetch
    cycle(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 5'b00101, 1'b1);
    expect_pred("repair_cycle", 32'h80, 1'b1, 5'b0);
    cycle(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'b0, 1'b0);
    expect_pred("repaired_ghr", GS ? 32'h44 : 32'h80, !GS, GS ? 5'b01011 : 5'b0);
    fetch_only(32'h40);
    expect_pred("spec_shift", GS ? 32'h44 : 32'h80, !GS, GS ? 5'b10110 : 5'b0);

    // non-conditional mispredict restores the snapshot verbatim
    cycle(32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 5'b00011, 1'b1);
    expect_pred("jal_repair_cycle", 32'h200, 1'b1, GS ? 5'b10110 : 5'b0);
    fetch_only(32'h100);
    expect_pred("jal_repaired_ghr", 32'h200, 1'b1, GS ? 5'b00011 : 5'b0);

    // asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b1;
    #1 expect_pred("async_reset", 32'h104, 1'b0, 5'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_pred("post_reset_jal_miss", 32'h104, 1'b0, 5'b0);
    fetch_only(32'h40); expect_pred("post_reset_br_miss", 32'h44, 1'b0, 5'b0);
    train_br40(1'b1);   expect_pred("post_reset_train", 32'h44, 1'b0, 5'b0);
    fetch_only(32'h40); expect_pred("post_reset_ctr_10", 32'h20, 1'b1, 5'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
